voxel_mem_wr_sched: RTL and testbench

Write-port scheduler for the voxel BRAM. It shares the single memory write port between three requesters:
- the CSR debug write pulse,
- a streaming bulk loader (valid/ready),
- an internal fill engine that clears or initialises address ranges.

It honours a renderer-owned block input and sits between the CSR block, the loader DMA and the voxel memory.

---
 rtl/voxel_mem_pkg.sv | 35 +++
 rtl/voxel_wr_fifo.sv | 64 ++++++
 rtl/voxel_mem_wr_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_voxel_mem_wr_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_mem_pkg.sv
// Shared definitions for the voxel memory write-port scheduler.
//   - default widths/depths for the scheduler parameters
//   - fill engine state encoding (plain constants so older tools and
//     checkers can compare against raw bit patterns)
//   - write source IDs and the round-robin pointer encoding
//   - saturating increment used by the optional statistics counters
package voxel_mem_pkg;

  localparam int ADDR_W_DEF    = 18;
  localparam int DATA_W_DEF    = 64;
  localparam int DBG_DEPTH_DEF = 2;
  localparam int CNT_W_DEF     = 19;

  // Fill engine states
  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_RUN  = 2'd1;
  localparam logic [1:0] F_DONE = 2'd2;

  // Source of the write currently on the memory port
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_DBG    = 2'd1,
    SRC_STREAM = 2'd2,
    SRC_FILL   = 2'd3
  } src_e;

  // Round-robin pointer: names the source preferred at the next contention
  localparam logic RR_STREAM = 1'b0;
  localparam logic RR_FILL   = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/voxel_wr_fifo.sv
// Small synchronous FIFO used to queue debug write pulses.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      write wdata_i; ignored while full (a same-cycle pop does
//               not make room, so "full" is purely the registered count)
//   pop_i       drop the head entry; ignored while empty
//   rdata_o     head entry, valid whenever empty_o is low (readable the
//               cycle after the push that wrote it)
//   full_o, empty_o  occupancy flags
module voxel_wr_fifo #(
  parameter int W     = 82,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap on their own
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/voxel_mem_wr_sched.sv
// Write-port scheduler for the voxel BRAM.
// Shares the single memory write port between the CSR debug write pulse
// (queued in a small FIFO), a streaming bulk loader (valid/ready) and an
// internal fill engine. Debug always wins; stream and fill alternate
// round-robin when both request. Nothing is written while mem_block is high.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   dbg_we_pulse/dbg_addr/dbg_wdata  debug write pulse, queued on arrival
//   s_valid/s_ready/s_addr/s_data    loader stream
//   fill_start/fill_abort            fill control pulses
//   fill_base/fill_count/fill_value  fill parameters, sampled at start
//   fill_busy/fill_done              fill status (done is a 1-cycle pulse)
//   mem_block                        renderer owns the memory
//   mem_we/mem_addr/mem_wdata        registered memory write port
//   dbg_overflow                     sticky: a debug pulse was dropped
//   fill_state_dbg                   fill engine state, for observation
//
// Build option VOXEL_WR_SCHED_STATS_EN adds stat_clr and three saturating
// 32-bit per-source write counters (stat_dbg_wr, stat_stream_wr,
// stat_fill_wr).
//
// Stream handshake: a beat transfers in every cycle where s_valid and
// s_ready are both high. s_ready is a function of scheduler state and
// mem_block only (never of s_valid), and the loader must hold s_addr/s_data
// stable while s_valid is high and s_ready is low.
module voxel_mem_wr_sched
  import voxel_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DBG_DEPTH = DBG_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_we_pulse,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [CNT_W-1:0]  fill_count,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              mem_block,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              dbg_overflow,
`ifdef VOXEL_WR_SCHED_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_dbg_wr,
  output logic [31:0]       stat_stream_wr,
  output logic [31:0]       stat_fill_wr,
`endif
  output logic [1:0]        fill_state_dbg
);

  localparam int FW = ADDR_W + DATA_W;

  // ---------------------------------------------------------------------
  // Debug FIFO
  // ---------------------------------------------------------------------
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0] fifo_head;

  voxel_wr_fifo #(
    .W     (FW),
    .DEPTH (DBG_DEPTH)
  ) u_dbg_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (dbg_we_pulse),
    .wdata_i ({dbg_addr, dbg_wdata}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              sched_en_q;  // low for the first cycle after reset so
                                  // s_ready stays 0 throughout reset
  logic              rr_q, rr_d;
  logic [1:0]        fill_state_q, fill_state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [CNT_W-1:0]  fill_rem_q, fill_rem_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ovf_q, ovf_d;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic port_free, fill_run;
  logic grant_dbg, grant_stream, grant_fill;

  assign fill_run  = (fill_state_q == F_RUN);
  assign port_free = sched_en_q && !mem_block;

  assign grant_dbg    = port_free && !fifo_empty;
  assign s_ready      = port_free && fifo_empty && (!fill_run || rr_q == RR_STREAM);
  assign grant_stream = s_valid && s_ready;
  // Fill takes the port whenever it runs and the stream does not take it:
  // either the pointer favours fill or the stream has nothing to send.
  assign grant_fill   = port_free && fifo_empty && fill_run && !grant_stream;
  assign fifo_pop     = grant_dbg;

  always_comb begin
    rr_d = rr_q;
    if (grant_stream)    rr_d = RR_FILL;
    else if (grant_fill) rr_d = RR_STREAM;
  end

  // ---------------------------------------------------------------------
  // Fill engine
  // ---------------------------------------------------------------------
  always_comb begin
    fill_state_d = fill_state_q;
    fill_addr_d  = fill_addr_q;
    fill_rem_d   = fill_rem_q;
    fill_val_d   = fill_val_q;
    case (fill_state_q)
      F_IDLE: begin
        if (fill_start) begin
          fill_addr_d  = fill_base;
          fill_rem_d   = fill_count;
          fill_val_d   = fill_value;
          fill_state_d = (fill_count == '0) ? F_DONE : F_RUN;
        end
      end
      F_RUN: begin
        if (grant_fill) begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          fill_rem_d  = fill_rem_q - CNT_W'(1);
        end
        if ((grant_fill && fill_rem_q == CNT_W'(1)) || fill_abort) begin
          fill_state_d = F_DONE;
        end
      end
      F_DONE:  fill_state_d = F_IDLE;
      default: fill_state_d = F_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output write port
  // ---------------------------------------------------------------------
  always_comb begin
    mem_we_d    = grant_dbg || grant_stream || grant_fill;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_dbg) begin
      {mem_addr_d, mem_wdata_d} = fifo_head;
    end else if (grant_stream) begin
      mem_addr_d  = s_addr;
      mem_wdata_d = s_data;
    end else if (grant_fill) begin
      mem_addr_d  = fill_addr_q;
      mem_wdata_d = fill_val_q;
    end
  end

  assign ovf_d = ovf_q || (dbg_we_pulse && fifo_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched_en_q   <= 1'b0;
      rr_q         <= RR_STREAM;
      fill_state_q <= F_IDLE;
      fill_addr_q  <= '0;
      fill_rem_q   <= '0;
      fill_val_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sched_en_q   <= 1'b1;
      rr_q         <= rr_d;
      fill_state_q <= fill_state_d;
      fill_addr_q  <= fill_addr_d;
      fill_rem_q   <= fill_rem_d;
      fill_val_q   <= fill_val_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ovf_q        <= ovf_d;
    end
  end

  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign dbg_overflow   = ovf_q;
  assign fill_busy      = fill_run;
  assign fill_done      = (fill_state_q == F_DONE);
  assign fill_state_dbg = fill_state_q;

`ifdef VOXEL_WR_SCHED_STATS_EN
  // ---------------------------------------------------------------------
  // Per-source write counters, advanced on each issued mem_we
  // ---------------------------------------------------------------------
  src_e        src_q, src_d;
  logic [31:0] st_dbg_q, st_stream_q, st_fill_q;

  always_comb begin
    src_d = SRC_NONE;
    if (grant_dbg)         src_d = SRC_DBG;
    else if (grant_stream) src_d = SRC_STREAM;
    else if (grant_fill)   src_d = SRC_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= SRC_NONE;
      st_dbg_q    <= '0;
      st_stream_q <= '0;
      st_fill_q   <= '0;
    end else begin
      src_q <= src_d;
      if (stat_clr) begin
        st_dbg_q    <= '0;
        st_stream_q <= '0;
        st_fill_q   <= '0;
      end else if (mem_we_q) begin
        case (src_q)
          SRC_DBG:    st_dbg_q    <= sat_inc(st_dbg_q);
          SRC_STREAM: st_stream_q <= sat_inc(st_stream_q);
          SRC_FILL:   st_fill_q   <= sat_inc(st_fill_q);
          default:    ;
        endcase
      end
    end
  end

  assign stat_dbg_wr    = st_dbg_q;
  assign stat_stream_wr = st_stream_q;
  assign stat_fill_wr   = st_fill_q;
`endif

endmodule

// File: tb/tb_voxel_mem_wr_sched.sv
// Bench for voxel_mem_wr_sched (default build).
// A behavioural model (queues and counters) predicts every registered
// output each cycle and s_ready mid-cycle; directed scenarios add
// hand-computed literal expectations on the logged write sequence.
`timescale 1ns/1ps
module tb_voxel_mem_wr_sched;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 64;
  localparam int DBG_DEPTH = 2;
  localparam int CNT_W     = 19;
  localparam logic [63:0] FILL_TAG_V = 64'hF1F1_F1F1_F1F1_F1F1;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dbg_we_pulse = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic              fill_start = 1'b0;
  logic              fill_abort = 1'b0;
  logic [ADDR_W-1:0] fill_base = '0;
  logic [CNT_W-1:0]  fill_count = '0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              fill_busy, fill_done;
  logic              mem_block = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              dbg_overflow;
  logic [1:0]        fill_state_dbg;

  always #5 clk = ~clk;

  voxel_mem_wr_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBG_DEPTH(DBG_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_we_pulse(dbg_we_pulse), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
    .fill_count(fill_count), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .mem_block(mem_block),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dbg_overflow(dbg_overflow), .fill_state_dbg(fill_state_dbg)
  );

  // ---------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] m_dbg_a[$];
  logic [DATA_W-1:0] m_dbg_d[$];
  bit                m_active, m_prefer_stream, m_run, m_done, m_fill_g, m_gate, m_full;
  logic [ADDR_W-1:0] m_fill_addr;
  int                m_fill_rem;
  logic [DATA_W-1:0] m_fill_val;
  logic              e_we, e_ovf;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dbg_a.delete(); m_dbg_d.delete();
      m_active = 0; m_prefer_stream = 1; m_run = 0; m_done = 0;
      m_fill_addr = '0; m_fill_rem = 0; m_fill_val = '0;
      e_we = 0; e_ovf = 0; e_addr = '0; e_data = '0;
    end else begin
      m_gate   = m_active && !mem_block;
      m_full   = (m_dbg_a.size() == DBG_DEPTH);
      m_fill_g = 0;
      e_we     = 0;
      if (m_gate && m_dbg_a.size() > 0) begin
        e_we = 1; e_addr = m_dbg_a.pop_front(); e_data = m_dbg_d.pop_front();
      end else if (m_gate && s_valid && (!m_run || m_prefer_stream)) begin
        e_we = 1; e_addr = s_addr; e_data = s_data; m_prefer_stream = 0;
      end else if (m_gate && m_run) begin
        e_we = 1; e_addr = m_fill_addr; e_data = m_fill_val;
        m_fill_g = 1; m_prefer_stream = 1;
      end
      if (dbg_we_pulse) begin
        if (m_full) e_ovf = 1;
        else begin m_dbg_a.push_back(dbg_addr); m_dbg_d.push_back(dbg_wdata); end
      end
      if (m_done) m_done = 0;
      else if (m_run) begin
        if (m_fill_g) begin m_fill_addr = m_fill_addr + 1'b1; m_fill_rem--; end
        if (m_fill_rem == 0 || fill_abort) begin m_run = 0; m_done = 1; end
      end else if (fill_start) begin
        m_fill_addr = fill_base; m_fill_rem = int'(fill_count); m_fill_val = fill_value;
        if (fill_count == 0) m_done = 1; else m_run = 1;
      end
      m_active = 1;
    end
  end

  // Registered outputs, checked just after each active edge; also logs writes
  logic [ADDR_W-1:0] log_a[$];
  logic [DATA_W-1:0] log_d[$];
  int                done_cnt = 0;

  always @(posedge clk) begin
    #1;
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", mem_wdata, e_data);
    chk("fill_busy", 64'(fill_busy), 64'(m_run));
    chk("fill_done", 64'(fill_done), 64'(m_done));
    chk("dbg_overflow", 64'(dbg_overflow), 64'(e_ovf));
    if (mem_we) begin log_a.push_back(mem_addr); log_d.push_back(mem_wdata); end
    if (fill_done) done_cnt++;
  end

  // s_ready, checked mid-cycle once the inputs for the cycle are applied
  always @(negedge clk) begin
    #1;
    chk("s_ready", 64'(s_ready),
        64'(m_active && !mem_block && m_dbg_a.size() == 0 && (!m_run || m_prefer_stream)));
  end

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  bit                stream_want = 0;
  bit                s_acc;
  logic [DATA_W-1:0] sent_q[$];

  task automatic new_beat();
    s_valid = 1'b1;
    s_addr  = ADDR_W'($urandom);
    s_data  = {8'hA5, 24'($urandom), 32'($urandom)};
  endtask

  // Call at a falling edge with this cycle's inputs applied; returns at the
  // next falling edge with pulses cleared and the stream advanced.
  task automatic tick();
    #1;
    s_acc = s_valid && s_ready;
    if (s_acc) sent_q.push_back(s_data);
    @(negedge clk);
    dbg_we_pulse = 0; fill_start = 0; fill_abort = 0;
    if (!s_valid || s_acc) begin
      if (stream_want) new_beat(); else s_valid = 1'b0;
    end
  endtask

  task automatic start_fill(input logic [ADDR_W-1:0] b, input int c, input logic [63:0] v);
    fill_start = 1; fill_base = b; fill_count = CNT_W'(c); fill_value = v;
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    for (int i = 0; i < budget && done_cnt == start_cnt; i++) tick();
    chk("fill_done_seen", 64'(done_cnt > start_cnt), 64'd1);
  endtask

  function automatic int count_data(input logic [63:0] v);
    int n = 0;
    foreach (log_d[i]) if (log_d[i] == v) n++;
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  int d0, nf, ns, first_f, last_f, alt_ok, sidx;
  logic [ADDR_W-1:0] wrap_exp[4];

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_fill_busy", 64'(fill_busy), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    chk("rst_overflow", 64'(dbg_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();

    // Single debug pulse: write two cycles later
    log_a.delete(); log_d.delete();
    dbg_we_pulse = 1; dbg_addr = 18'h00123; dbg_wdata = 64'hDEADBEEF_CAFEF00D;
    @(posedge clk); #2;
    chk("dbg_lat_t1_we", 64'(mem_we), 64'd0);
    @(negedge clk); dbg_we_pulse = 0;
    @(posedge clk); #2;
    chk("dbg_lat_t2_we", 64'(mem_we), 64'd1);
    chk("dbg_lat_addr", 64'(mem_addr), 64'h00123);
    chk("dbg_lat_data", mem_wdata, 64'hDEADBEEF_CAFEF00D);
    chk("dbg_lat_ovf", 64'(dbg_overflow), 64'd0);
    @(negedge clk);
    repeat (2) tick();

    // Three pulses under block: two survive in order, third overflows
    log_a.delete(); log_d.delete();
    mem_block = 1; tick();
    for (int k = 0; k < 3; k++) begin
      dbg_we_pulse = 1; dbg_addr = ADDR_W'(18'h10 + k);
      dbg_wdata = {16{4'(k + 1)}};
      tick();
    end
    repeat (7) tick();
    mem_block = 0;
    repeat (5) tick();
    chk("blk_wr_count", 64'(log_a.size()), 64'd2);
    if (log_a.size() >= 2) begin
      chk("blk_wr0_addr", 64'(log_a[0]), 64'h10);
      chk("blk_wr0_data", log_d[0], 64'h1111_1111_1111_1111);
      chk("blk_wr1_addr", 64'(log_a[1]), 64'h11);
      chk("blk_wr1_data", log_d[1], 64'h2222_2222_2222_2222);
    end
    chk("blk_overflow", 64'(dbg_overflow), 64'd1);

    // Fill across the top of the address space
    log_a.delete(); log_d.delete();
    wrap_exp = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    d0 = done_cnt;
    start_fill(18'h3FFFE, 4, 64'h55);
    tick();
    wait_done(d0, 20);
    repeat (3) tick();
    chk("wrap_count", 64'(log_a.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_a.size(); i++) begin
      chk("wrap_addr", 64'(log_a[i]), 64'(wrap_exp[i]));
      chk("wrap_data", log_d[i], 64'h55);
    end
    chk("wrap_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("wrap_busy_after", 64'(fill_busy), 64'd0);

    // Fill of 100 against a continuous stream
    log_a.delete(); log_d.delete(); sent_q.delete();
    d0 = done_cnt;
    stream_want = 1; new_beat();
    start_fill(18'h01000, 100, FILL_TAG_V);
    tick();
    wait_done(d0, 400);
    stream_want = 0;
    for (int i = 0; i < 10 && s_valid; i++) tick();
    repeat (3) tick();
    nf = 0; ns = 0; first_f = -1; last_f = -1; alt_ok = 1; sidx = 0;
    foreach (log_d[i]) begin
      if (log_d[i] == FILL_TAG_V) begin
        nf++; if (first_f < 0) first_f = i; last_f = i;
      end else begin
        ns++;
        if (sidx < sent_q.size() && log_d[i] != sent_q[sidx]) alt_ok = 0;
        sidx++;
      end
    end
    chk("rr_fill_writes", 64'(nf), 64'd100);
    chk("rr_stream_beats", 64'(ns), 64'(sent_q.size()));
    chk("rr_stream_order", 64'(alt_ok), 64'd1);
    alt_ok = 1;
    for (int i = first_f + 1; i <= last_f && first_f >= 0; i++)
      if ((log_d[i] == FILL_TAG_V) == (log_d[i-1] == FILL_TAG_V)) alt_ok = 0;
    chk("rr_alternate", 64'(alt_ok), 64'd1);
    chk("rr_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Zero-count fill: done next cycle, no write
    log_a.delete(); log_d.delete();
    start_fill(18'h00200, 0, 64'h66);
    @(posedge clk); #2;
    chk("zero_done_t1", 64'(fill_done), 64'd1);
    chk("zero_we_t1", 64'(mem_we), 64'd0);
    @(negedge clk); fill_start = 0;
    @(posedge clk); #2;
    chk("zero_done_t2", 64'(fill_done), 64'd0);
    @(negedge clk);
    repeat (3) tick();
    chk("zero_no_writes", 64'(log_a.size()), 64'd0);

    // Count 50, abort in the cycle of the 10th write
    log_a.delete(); log_d.delete();
    d0 = done_cnt;
    start_fill(18'h00100, 50, 64'h77);
    tick();
    repeat (9) tick();
    fill_abort = 1;
    tick();
    repeat (5) tick();
    chk("abort_writes", 64'(count_data(64'h77)), 64'd10);
    chk("abort_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("abort_busy_after", 64'(fill_busy), 64'd0);

    // Reset in the middle of a fill
    log_a.delete(); log_d.delete();
    start_fill(18'h02000, 20, 64'h99);
    tick();
    for (int i = 0; i < 30 && log_a.size() < 5; i++) tick();
    chk("midrst_progress", 64'(log_a.size()), 64'd5);
    #3 rst_n = 0;
    #1;
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_fill_busy", 64'(fill_busy), 64'd0);
    chk("midrst_fill_done", 64'(fill_done), 64'd0);
    chk("midrst_overflow", 64'(dbg_overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    log_a.delete(); log_d.delete();
    d0 = done_cnt;
    repeat (30) tick();
    chk("midrst_no_writes", 64'(log_a.size()), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    // Randomised mix checked against the model every cycle
    for (int c = 0; c < 1500; c++) begin
      mem_block   = ($urandom_range(0, 99) < 15);
      stream_want = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 8) begin
        dbg_we_pulse = 1; dbg_addr = ADDR_W'($urandom);
        dbg_wdata = {32'($urandom), 32'($urandom)};
      end
      if ($urandom_range(0, 99) < 4)
        start_fill(($urandom_range(0, 1) == 1) ? ADDR_W'(18'h3FFF8 + $urandom_range(0, 7))
                                               : ADDR_W'($urandom),
                   $urandom_range(0, 10), {32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 99) < 3) fill_abort = 1;
      tick();
    end
    mem_block = 0; stream_want = 0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
